// File: rtl/gem_cluster_pkg.sv
// rtl/gem_cluster_pkg.sv - shared cluster-selector defaults, clog2 helper and lane-state enum
package gem_cluster_pkg;

  localparam int MXCLUSTERS_DEF = 1536;
  localparam int ADR_W_DEF      = 11;
  localparam int CNT_W_DEF      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lane_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/first1_of_m_enc.sv
// rtl/first1_of_m_enc.sv - combinational lowest-set-bit encoder built as a balanced binary tree
module first1_of_m_enc
  import gem_cluster_pkg::*;
#(
  parameter int M     = MXCLUSTERS_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic [M-1:0]     mask,
  output logic [ADR_W-1:0] adr,
  output logic             any
);

  localparam int L = clog2(M);
  localparam int P = 1 << L;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  logic             any_t [2*P-1];
  logic [ADR_W-1:0] adr_t [2*P-1];

  always_comb begin
    for (int i = 0; i < 2*P-1; i++) begin
      any_t[i] = 1'b0;
      adr_t[i] = '0;
    end
    for (int i = 0; i < M; i++) begin
      any_t[P-1+i] = mask[i];
    end
    for (int d = L-1; d >= 0; d--) begin
      for (int j = 0; j < (1 << d); j++) begin
        any_t[(1 << d)-1+j] = any_t[2*((1 << d)-1+j)+1] | any_t[2*((1 << d)-1+j)+2];
        adr_t[(1 << d)-1+j] = any_t[2*((1 << d)-1+j)+1] ? adr_t[2*((1 << d)-1+j)+1]
                            : (adr_t[2*((1 << d)-1+j)+2] | (ADR_W'(1) << (L-1-d)));
      end
    end
  end

  assign adr = adr_t[0];
  assign any = any_t[0];

endmodule

// File: rtl/firstn_of_m_mux.sv
// rtl/firstn_of_m_mux.sv - lane-interleaved first-N-of-M cluster selector with fixed-latency publish
module firstn_of_m_mux
  import gem_cluster_pkg::*;
#(
  parameter int MXCLUSTERS = MXCLUSTERS_DEF,
  parameter int MXOUT      = 8,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ADR_W      = ADR_W_DEF,
  parameter int NLANES     = 3,
  parameter int FRAME_CYC  = 4,
  parameter int OFFSET     = 2
) (
  input  logic                        clock4x,
  input  logic                        global_reset_n,
  input  logic [MXCLUSTERS-1:0]       vpfs,
  input  logic [MXCLUSTERS*CNT_W-1:0] cnts,
  output logic [MXOUT*ADR_W-1:0]      adr,
  output logic [MXOUT*CNT_W-1:0]      cnt,
  output logic [MXOUT-1:0]            vld,
  output logic                        overflow,
  output logic                        frame_valid,
  output logic                        busy_err
);

  localparam int PW  = (FRAME_CYC > 1) ? clog2(FRAME_CYC) : 1;
  localparam int LPW = (NLANES > 1) ? clog2(NLANES) : 1;
  localparam int KW  = (MXOUT > 1) ? clog2(MXOUT) : 1;
  localparam logic [MXCLUSTERS-1:0] ONE = {{(MXCLUSTERS-1){1'b0}}, 1'b1};

  if (NLANES*FRAME_CYC < MXOUT+1) begin : g_bad_lanes
    $error("firstn_of_m_mux: NLANES*FRAME_CYC must be >= MXOUT+1");
  end
  if (ADR_W < clog2(MXCLUSTERS)) begin : g_bad_adr_w
    $error("firstn_of_m_mux: ADR_W too narrow for MXCLUSTERS");
  end

  logic [PW-1:0]  phase;
  logic [LPW-1:0] lane_ptr;
  logic           frame_start;

  logic [MXOUT*ADR_W-1:0] lane_adr [NLANES];
  logic [MXOUT*CNT_W-1:0] lane_cnt [NLANES];
  logic [MXOUT-1:0]       lane_vld [NLANES];
  logic [NLANES-1:0]      lane_ovf;
  logic [NLANES-1:0]      lane_cap;
  logic [NLANES-1:0]      lane_busy;

  assign frame_start = (phase == PW'(FRAME_CYC-1));

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      phase    <= PW'(OFFSET);
      lane_ptr <= '0;
    end else begin
      phase <= frame_start ? '0 : phase + PW'(1);
      if (frame_start) begin
        lane_ptr <= (lane_ptr == LPW'(NLANES-1)) ? '0 : lane_ptr + LPW'(1);
      end
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    lane_state_e              state;
    logic [MXCLUSTERS-1:0]       mask;
    logic [MXCLUSTERS*CNT_W-1:0] cstore;
    logic [KW-1:0]               k;
    logic [MXOUT*ADR_W-1:0]      s_adr;
    logic [MXOUT*CNT_W-1:0]      s_cnt;
    logic [MXOUT-1:0]            s_vld;
    logic                        ovf;
    logic                        captured;
    logic [ADR_W-1:0]            e_adr;
    logic                        e_any;
    logic [MXCLUSTERS-1:0]       mask_rest;
    logic                        sel;

    first1_of_m_enc #(.M(MXCLUSTERS), .ADR_W(ADR_W)) u_enc (
      .mask (mask),
      .adr  (e_adr),
      .any  (e_any)
    );

    // Mask with its lowest set bit cleared, i.e. what remains after this cycle's extraction.
    assign mask_rest = mask & (mask - ONE);
    assign sel       = frame_start && (lane_ptr == LPW'(l));

    always_ff @(posedge clock4x or negedge global_reset_n) begin
      if (!global_reset_n) begin
        state    <= IDLE;
        mask     <= '0;
        cstore   <= '0;
        k        <= '0;
        s_adr    <= '0;
        s_cnt    <= '0;
        s_vld    <= '0;
        ovf      <= 1'b0;
        captured <= 1'b0;
      end else if (sel) begin
        state    <= SCAN;
        mask     <= vpfs;
        cstore   <= cnts;
        k        <= '0;
        s_adr    <= '0;
        s_cnt    <= '0;
        s_vld    <= '0;
        ovf      <= 1'b0;
        captured <= 1'b1;
      end else if (state == SCAN) begin
        if (!e_any) begin
          state <= DONE;
        end else begin
          s_adr[k*ADR_W +: ADR_W] <= e_adr;
          s_cnt[k*CNT_W +: CNT_W] <= cstore[e_adr*CNT_W +: CNT_W];
          s_vld[k]                <= 1'b1;
          mask                    <= mask_rest;
          k                       <= k + KW'(1);
          // Leave on the last extraction so a full frame is DONE by c0+MXOUT.
          if (k == KW'(MXOUT-1) || !(|mask_rest)) begin
            state <= DONE;
            ovf   <= (k == KW'(MXOUT-1)) && (|mask_rest);
          end
        end
      end
    end

    assign lane_adr[l]  = s_adr;
    assign lane_cnt[l]  = s_cnt;
    assign lane_vld[l]  = s_vld;
    assign lane_ovf[l]  = ovf;
    assign lane_cap[l]  = captured;
    assign lane_busy[l] = (state == SCAN);
  end

  // Publish reads pre-edge lane results, so a same-edge recapture cannot bypass into the outputs.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      adr         <= '0;
      cnt         <= '0;
      vld         <= '0;
      overflow    <= 1'b0;
      frame_valid <= 1'b0;
      busy_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (frame_start) begin
        adr         <= lane_adr[lane_ptr];
        cnt         <= lane_cnt[lane_ptr];
        vld         <= lane_vld[lane_ptr];
        overflow    <= lane_ovf[lane_ptr];
        frame_valid <= lane_cap[lane_ptr];
        if (lane_busy[lane_ptr]) busy_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_firstn_of_m_mux.sv
// tb/tb_firstn_of_m_mux.sv - table-driven bench for firstn_of_m_mux at default parameters
module tb_firstn_of_m_mux;

  localparam int MXC   = 1536;
  localparam int MXOUT = 8;
  localparam int CNT_W = 3;
  localparam int ADR_W = 11;
  localparam int NV    = 7;

  typedef struct {
    logic [MXC-1:0]         vpfs;
    logic [MXC*CNT_W-1:0]   cnts;
    logic [MXOUT*ADR_W-1:0] adr;
    logic [MXOUT*CNT_W-1:0] cnt;
    logic [MXOUT-1:0]       vld;
    logic                   ovf;
  } vec_t;

  vec_t tbl [NV];
  vec_t zero_v;

  logic                   clock4x = 1'b0;
  logic                   global_reset_n = 1'b0;
  logic [MXC-1:0]         vpfs;
  logic [MXC*CNT_W-1:0]   cnts;
  logic [MXOUT*ADR_W-1:0] adr;
  logic [MXOUT*CNT_W-1:0] cnt;
  logic [MXOUT-1:0]       vld;
  logic                   overflow;
  logic                   frame_valid;
  logic                   busy_err;

  int n_vec = 0;
  int n_bad = 0;

  firstn_of_m_mux #(
    .MXCLUSTERS(MXC), .MXOUT(MXOUT), .CNT_W(CNT_W), .ADR_W(ADR_W),
    .NLANES(3), .FRAME_CYC(4), .OFFSET(2)
  ) dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .vpfs           (vpfs),
    .cnts           (cnts),
    .adr            (adr),
    .cnt            (cnt),
    .vld            (vld),
    .overflow       (overflow),
    .frame_valid    (frame_valid),
    .busy_err       (busy_err)
  );

  always #5 clock4x = ~clock4x;

  task automatic clr(input int f);
    tbl[f].vpfs = '0;
    tbl[f].cnts = '0;
    tbl[f].adr  = '0;
    tbl[f].cnt  = '0;
    tbl[f].vld  = '0;
    tbl[f].ovf  = 1'b0;
  endtask

  task automatic stim(input int f, input int a, input int c);
    tbl[f].vpfs[a] = 1'b1;
    tbl[f].cnts[a*CNT_W +: CNT_W] = CNT_W'(c);
  endtask

  task automatic exp_slot(input int f, input int k, input int a, input int c);
    tbl[f].adr[k*ADR_W +: ADR_W] = ADR_W'(a);
    tbl[f].cnt[k*CNT_W +: CNT_W] = CNT_W'(c);
    tbl[f].vld[k] = 1'b1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic fv, input vec_t e);
    check({tag, " frame_valid"}, 128'(frame_valid), 128'(fv));
    check({tag, " adr"}, 128'(adr), 128'(e.adr));
    check({tag, " cnt"}, 128'(cnt), 128'(e.cnt));
    check({tag, " vld"}, 128'(vld), 128'(e.vld));
    check({tag, " overflow"}, 128'(overflow), 128'(e.ovf));
    check({tag, " busy_err"}, 128'(busy_err), 128'(0));
  endtask

  task automatic apply(input int f);
    vpfs = tbl[f].vpfs;
    cnts = tbl[f].cnts;
  endtask

  task automatic apply_zero();
    vpfs = '0;
    cnts = '0;
  endtask

  // Entered right after reset release at a negedge: capture edges are the 2nd, 6th, 10th... edges.
  task automatic run_seq(input int start, input int n);
    apply(start);
    @(posedge clock4x);
    for (int f = 0; f < n + 3; f++) begin
      @(posedge clock4x);
      #1;
      if (f + 1 < n) apply(start + f + 1);
      else apply_zero();
      @(negedge clock4x);
      if (f >= 3) check_out($sformatf("f%0d publish", start + f - 3), 1'b1, tbl[start + f - 3]);
      else check_out($sformatf("slot%0d early", f), 1'b0, zero_v);
      repeat (3) @(posedge clock4x);
      @(negedge clock4x);
      if (f >= 3) check_out($sformatf("f%0d hold", start + f - 3), 1'b0, tbl[start + f - 3]);
      else check_out($sformatf("slot%0d early hold", f), 1'b0, zero_v);
    end
  endtask

  int c1 [8] = '{3, 4, 5, 6, 7, 0, 1, 2};
  int a3 [8] = '{1, 2, 100, 200, 300, 1000, 1500, 1534};
  int n3 [8] = '{7, 6, 5, 4, 3, 2, 1, 7};

  initial begin
    zero_v.vpfs = '0; zero_v.cnts = '0; zero_v.adr = '0;
    zero_v.cnt = '0; zero_v.vld = '0; zero_v.ovf = 1'b0;
    for (int f = 0; f < NV; f++) clr(f);

    // sparse
    stim(0, 700, 4); stim(0, 5, 1); stim(0, 1535, 7);
    exp_slot(0, 0, 5, 1); exp_slot(0, 1, 700, 4); exp_slot(0, 2, 1535, 7);
    // overflow: bits 0..9
    for (int i = 0; i < 10; i++) stim(1, i, (i + 3) % 8);
    for (int k = 0; k < 8; k++) exp_slot(1, k, k, c1[k]);
    tbl[1].ovf = 1'b1;
    // 2: empty frame
    // A: exactly MXOUT valid, plus a stray count on an invalid cluster
    for (int i = 7; i >= 0; i--) stim(3, a3[i], n3[i]);
    tbl[3].cnts[0 +: CNT_W] = 3'd5;
    for (int k = 0; k < 8; k++) exp_slot(3, k, a3[k], n3[k]);
    // B: single lowest cluster
    stim(4, 0, 5);
    tbl[4].cnts[1*CNT_W +: CNT_W] = 3'd6;
    exp_slot(4, 0, 0, 5);
    // C: top ten clusters overflow
    for (int i = 1526; i < 1536; i++) stim(5, i, 3);
    for (int k = 0; k < 8; k++) exp_slot(5, k, 1526 + k, 3);
    tbl[5].ovf = 1'b1;
    // D: all counts saturated except the valid ones
    tbl[6].cnts = '1;
    stim(6, 3, 1); stim(6, 64, 2); stim(6, 65, 7);
    exp_slot(6, 0, 3, 1); exp_slot(6, 1, 64, 2); exp_slot(6, 2, 65, 7);

    apply_zero();
    repeat (3) @(posedge clock4x);
    @(negedge clock4x);
    check_out("in reset", 1'b0, zero_v);
    global_reset_n = 1'b1;
    run_seq(0, NV);

    // Reset in the middle of a scan, with frame D still on the outputs.
    apply(1);
    @(posedge clock4x);
    @(posedge clock4x);
    #2 global_reset_n = 1'b0;
    #1 check_out("midscan reset", 1'b0, zero_v);
    repeat (2) @(negedge clock4x);
    global_reset_n = 1'b1;
    run_seq(0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
